apb_master_ctrl_p: RTL and testbench
====================================

// Module: apb_master_ctrl_p
// PURPOSE
//  Parametrised APB master controller for the AHB-to-APB bridge. Converts one registered AHB
//  request (from the AHB slave interface) into an APB3 SETUP/ACCESS sequence with PREADY wait
//  states and PSLVERR, returning read data and a two-cycle AHB ERROR response. One transfer
//  outstanding; successor to the fixed 32-bit/3-slave controller.
// PARAMETERS
//  ADDR_W      32  address width (haddr, paddr)
//  DATA_W      32  data width (hwdata, pwdata, prdata, hrdata)
//  NUM_SLV     3   APB slave count; width of tempselx and psel (one-hot)
//  TIMEOUT_CYC 16  ACCESS wait-state limit, used only with APB_TIMEOUT_EN; must be >= 1
// PORTS
//  hclk        in   1        clock, all flops rising edge
//  hresetn     in   1        reset, asynchronous, active-low
//  valid       in   1        AHB request valid (NONSEQ/SEQ to bridge), sampled only when hr_readyout=1
//  hwrite      in   1        request direction, 1=write
//  haddr       in   ADDR_W   request address
//  hwdata      in   DATA_W   write data, valid in cycle after address phase
//  tempselx    in   NUM_SLV  one-hot slave decode for haddr; all-zero = unmapped
//  prdata      in   DATA_W   APB read data
//  pready      in   1        APB ready
//  pslverr     in   1        APB slave error, valid when pready=1 in ACCESS
//  paddr       out  ADDR_W   APB address
//  pwdata      out  DATA_W   APB write data
//  pwrite      out  1        APB direction
//  psel        out  NUM_SLV  APB select, one-hot
//  penable     out  1        APB enable
//  hr_readyout out  1        AHB HREADYOUT
//  hresp       out  1        AHB HRESP, 1=ERROR
//  hrdata      out  DATA_W   AHB read data
// BEHAVIOUR
//  - All outputs registered, state-decoded. Reset (hresetn=0, async): state IDLE; paddr, pwdata,
//    pwrite, psel, penable, hresp, hrdata = 0; hr_readyout = 1. Reset mid-transfer drops psel/penable at once.
//  - States: IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2.
//  - IDLE (hr_readyout=1, psel=0, penable=0): on valid: latch haddr->paddr, hwrite->pwrite, tempselx
//    into select reg. tempselx==0 -> ERR1 (decode error, no APB cycle). Else hwrite=1 -> WWAIT, hwrite=0 -> SETUP.
//  - WWAIT (hr_readyout=0): latch hwdata->pwdata; -> SETUP.
//  - SETUP: psel=select reg, penable=0, hr_readyout=0; -> ACCESS.
//  - ACCESS: psel held, penable=1, paddr/pwrite/pwdata stable. pready=0 -> stay.
//    pready=1,pslverr=0 -> IDLE; on reads capture prdata->hrdata same edge.
//    pready=1,pslverr=1 -> ERR1; hrdata not updated.
//  - ERR1: hresp=1, hr_readyout=0, psel=0, penable=0; -> ERR2.
//  - ERR2: hresp=1, hr_readyout=1; valid ignored; -> IDLE (hresp=0).
//  - Latency, zero wait states: read valid@T0 -> hr_readyout=1 with hrdata@T3; write valid@T0 -> done@T4.
//    Each pready=0 cycle in ACCESS adds one cycle. Back-to-back: valid in completion IDLE cycle accepted.
//  - paddr/pwrite/pwdata hold last values in IDLE; hrdata holds until next successful read.
//  - Multi-hot tempselx is illegal; not checked in RTL, flagged by bench assertion.
// CONFIGURATION
//  - APB_TIMEOUT_EN defined: counter (width clog2(TIMEOUT_CYC+1)) clears on SETUP entry, increments
//    each ACCESS cycle with pready=0; when it reaches TIMEOUT_CYC with pready=0, -> ERR1 (treated
//    as slave error; psel/penable drop). pready=1 on the limit cycle completes normally.
//  - Not defined: no counter; ACCESS waits for pready indefinitely.
// TESTING
//  - Reset: hresetn=0 mid-ACCESS -> psel=0, penable=0, hr_readyout=1 without clock edge; IDLE after release.
//  - Read, zero wait: haddr=0x8000_0010, tempselx=001, prdata=0xDEAD_BEEF, pready=1 -> SETUP@T1, ACCESS@T2,
//    hr_readyout=1, hrdata=0xDEAD_BEEF@T3.
//  - Write, 3 wait states: hwdata=0x1234_5678 @T1, pready low 3 ACCESS cycles -> pwdata stable 0x1234_5678,
//    penable high 4 cycles, hr_readyout=1 @T7.
//  - Slave error: read, pready=1, pslverr=1 -> hresp=1/hr_readyout=0 then hresp=1/hr_readyout=1,
//    hrdata unchanged, IDLE next.
//  - Decode error: valid, tempselx=000 -> no psel pulse, ERR1 then ERR2 immediately.
//  - APB_TIMEOUT_EN, TIMEOUT_CYC=4, pready stuck 0 -> ERR1 after 4 ACCESS cycles; without macro, still in ACCESS at 100 cycles.

Source files
------------

// File: rtl/apb_master_ctrl_p.sv
// apb_master_ctrl_p: APB3 master for the AHB-to-APB bridge, one transfer in flight.
// Optional feature macro APB_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYC wait states as an ERROR.
module apb_master_ctrl_p #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_SLV     = 3,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               valid,
  input  logic               hwrite,
  input  logic [ADDR_W-1:0]  haddr,
  input  logic [DATA_W-1:0]  hwdata,
  input  logic [NUM_SLV-1:0] tempselx,
  input  logic [DATA_W-1:0]  prdata,
  input  logic               pready,
  input  logic               pslverr,
  output logic [ADDR_W-1:0]  paddr,
  output logic [DATA_W-1:0]  pwdata,
  output logic               pwrite,
  output logic [NUM_SLV-1:0] psel,
  output logic               penable,
  output logic               hr_readyout,
  output logic               hresp,
  output logic [DATA_W-1:0]  hrdata
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWwait  = 3'd1;
  localparam logic [2:0] StSetup  = 3'd2;
  localparam logic [2:0] StAccess = 3'd3;
  localparam logic [2:0] StErr1   = 3'd4;
  localparam logic [2:0] StErr2   = 3'd5;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  logic [2:0]         state_q, state_d;
  logic [NUM_SLV-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic               pwrite_q, pwrite_d;
  logic [NUM_SLV-1:0] psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               hready_q, hready_d;
  logic               hresp_q, hresp_d;
  logic [DATA_W-1:0]  hrdata_q, hrdata_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counts ACCESS cycles spent waiting on pready for the current transfer.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == StSetup) begin
      cnt_d = '0;
    end else if (state_q == StAccess && !pready) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    unique case (state_q)
      StIdle: begin
        if (valid) begin
          paddr_d  = haddr;
          pwrite_d = hwrite;
          sel_d    = tempselx;
          if (tempselx == '0) begin
            state_d = StErr1;
          end else if (hwrite) begin
            state_d = StWwait;
          end else begin
            state_d = StSetup;
          end
        end
      end
      StWwait: begin
        pwdata_d = hwdata;
        state_d  = StSetup;
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (pready) begin
          if (pslverr) begin
            state_d = StErr1;
          end else begin
            state_d = StIdle;
            if (!pwrite_q) hrdata_d = prdata;
          end
        end else begin
`ifdef APB_TIMEOUT_EN
          if (cnt_q == CntLast) state_d = StErr1;
`endif
        end
      end
      StErr1:  state_d = StErr2;
      StErr2:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every output comes straight from a flop.
  always_comb begin
    psel_d    = '0;
    penable_d = 1'b0;
    hready_d  = 1'b1;
    hresp_d   = 1'b0;
    case (state_d)
      StWwait: hready_d = 1'b0;
      StSetup: begin
        psel_d   = sel_d;
        hready_d = 1'b0;
      end
      StAccess: begin
        psel_d    = sel_d;
        penable_d = 1'b1;
        hready_d  = 1'b0;
      end
      StErr1: begin
        hresp_d  = 1'b1;
        hready_d = 1'b0;
      end
      StErr2:  hresp_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      hready_q  <= 1'b1;
      hresp_q   <= 1'b0;
      hrdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
      hrdata_q  <= hrdata_d;
    end
  end

  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pwrite      = pwrite_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign hr_readyout = hready_q;
  assign hresp       = hresp_q;
  assign hrdata      = hrdata_q;

endmodule

// File: tb/tb_apb_master_ctrl_p.sv
// Self-checking bench for apb_master_ctrl_p: directed table, random transactions against a
// transaction-level expected-trace model, plus reset and stuck-pready sequences.
module tb_apb_master_ctrl_p;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 3;
  localparam int unsigned TO = 4;

  localparam int KOther  = 0;
  localparam int KWwait  = 1;
  localparam int KAccess = 2;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          valid, hwrite, pready, pslverr;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata, prdata;
  logic [NS-1:0] tempselx;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, hrdata;
  logic          pwrite, penable, hr_readyout, hresp;
  logic [NS-1:0] psel;

  always #5 hclk = ~hclk;

  apb_master_ctrl_p #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .NUM_SLV    (NS),
    .TIMEOUT_CYC(TO)
  ) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .valid      (valid),
    .hwrite     (hwrite),
    .haddr      (haddr),
    .hwdata     (hwdata),
    .tempselx   (tempselx),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pwrite     (pwrite),
    .psel       (psel),
    .penable    (penable),
    .hr_readyout(hr_readyout),
    .hresp      (hresp),
    .hrdata     (hrdata)
  );

  typedef struct {
    logic [NS-1:0] psel;
    logic          penable;
    logic          rdy;
    logic          resp;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] hrdata;
    int            kind;
  } snap_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [NS-1:0] sel;
    logic [DW-1:0] rdata;
    int            waits;
    logic          err;
    int            exp_cycles;
    logic [DW-1:0] exp_hrdata;
  } txn_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] m_paddr  = '0;
  logic          m_pwrite = 1'b0;
  logic [DW-1:0] m_pwdata = '0;
  logic [DW-1:0] m_hrdata = '0;
  snap_t         exp_q[$];

  // Only a sampled request may carry a select; multi-hot decode is illegal there.
  always @(posedge hclk) begin
    if (hresetn && valid && hr_readyout && !hresp) begin
      assert ($countones(tempselx) <= 1) else $error("multi-hot tempselx %b", tempselx);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NS-1:0] rand_sel();
    logic [NS-1:0] s;
    int k;
    s = '0;
    k = $urandom_range(0, NS);
    if (k < NS) s[k] = 1'b1;
    return s;
  endfunction

  function automatic txn_t mk(input logic wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [NS-1:0] sel,
                              input logic [DW-1:0] rdata, input int waits, input logic err,
                              input int cyc, input logic [DW-1:0] hrd);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.sel = sel; t.rdata = rdata;
    t.waits = waits; t.err = err; t.exp_cycles = cyc; t.exp_hrdata = hrd;
    return t;
  endfunction

  task automatic check(input string name, input logic ok, input string got, input string want);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, want %s", name, got, want);
    end
  endtask

  task automatic push(input logic [NS-1:0] ps, input logic pe, input logic rdy,
                      input logic rsp, input int kind);
    snap_t s;
    s.psel = ps; s.penable = pe; s.rdy = rdy; s.resp = rsp; s.kind = kind;
    s.paddr = m_paddr; s.pwrite = m_pwrite; s.pwdata = m_pwdata; s.hrdata = m_hrdata;
    exp_q.push_back(s);
  endtask

  // Expected per-cycle outputs, one entry per clock after the request is sampled.
  task automatic model_txn(input txn_t t);
    int   n_acc;
    logic abort;
    exp_q.delete();
    m_paddr  = t.addr;
    m_pwrite = t.wr;
    if (t.sel == '0) begin
      push('0, 1'b0, 1'b0, 1'b1, KOther);
      push('0, 1'b0, 1'b1, 1'b1, KOther);
      push('0, 1'b0, 1'b1, 1'b0, KOther);
      return;
    end
    if (t.wr) begin
      push('0, 1'b0, 1'b0, 1'b0, KWwait);
      m_pwdata = t.wdata;
    end
    push(t.sel, 1'b0, 1'b0, 1'b0, KOther);
    n_acc = t.waits + 1;
    abort = t.err;
`ifdef APB_TIMEOUT_EN
    if (t.waits >= int'(TO)) begin
      n_acc = TO;
      abort = 1'b1;
    end
`endif
    repeat (n_acc) push(t.sel, 1'b1, 1'b0, 1'b0, KAccess);
    if (abort) begin
      push('0, 1'b0, 1'b0, 1'b1, KOther);
      push('0, 1'b0, 1'b1, 1'b1, KOther);
    end else if (!t.wr) begin
      m_hrdata = t.rdata;
    end
    push('0, 1'b0, 1'b1, 1'b0, KOther);
  endtask

  // Starts mid-IDLE-cycle (so consecutive calls are back-to-back) and ends mid-IDLE-cycle.
  task automatic run_txn(input txn_t t, input string name);
    int    acc_k;
    int    seen;
    snap_t e;
    model_txn(t);
    valid = 1'b1; hwrite = t.wr; haddr = t.addr; tempselx = t.sel;
    hwdata = $urandom; prdata = $urandom; pready = $urandom; pslverr = $urandom;
    acc_k = 0;
    seen  = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      @(posedge hclk);
      #1;
      valid = (i == exp_q.size() - 1) ? 1'b0 : 1'($urandom);
      hwrite = $urandom; haddr = $urandom; tempselx = rand_sel();
      hwdata = $urandom; prdata = $urandom; pready = $urandom; pslverr = $urandom;
      if (e.kind == KWwait) hwdata = t.wdata;
      if (e.kind == KAccess) begin
        pready = (acc_k == t.waits);
        if (pready) begin
          pslverr = t.err;
          prdata  = t.rdata;
        end
        acc_k++;
      end
      @(negedge hclk);
      check($sformatf("%s cyc%0d", name, i + 1),
            psel === e.psel && penable === e.penable && hr_readyout === e.rdy &&
            hresp === e.resp && paddr === e.paddr && pwrite === e.pwrite &&
            pwdata === e.pwdata && hrdata === e.hrdata,
            $sformatf("sel=%b en=%b rdy=%b resp=%b a=%h w=%b wd=%h rd=%h", psel, penable,
                      hr_readyout, hresp, paddr, pwrite, pwdata, hrdata),
            $sformatf("sel=%b en=%b rdy=%b resp=%b a=%h w=%b wd=%h rd=%h", e.psel, e.penable,
                      e.rdy, e.resp, e.paddr, e.pwrite, e.pwdata, e.hrdata));
      if (seen == 0 && hr_readyout === 1'b1) seen = i + 1;
    end
    if (t.exp_cycles > 0) begin
      check({name, " latency"}, seen == t.exp_cycles, $sformatf("T%0d", seen),
            $sformatf("T%0d", t.exp_cycles));
      check({name, " hrdata"}, hrdata === t.exp_hrdata, $sformatf("%h", hrdata),
            $sformatf("%h", t.exp_hrdata));
    end
  endtask

  txn_t tbl[6];

  initial begin
    tbl[0] = mk(1'b0, 32'h8000_0010, 32'h0, 3'b001, 32'hDEAD_BEEF, 0, 1'b0, 3, 32'hDEAD_BEEF);
    tbl[1] = mk(1'b1, 32'h4000_0020, 32'h1234_5678, 3'b010, 32'h0, 3, 1'b0, 7, 32'hDEAD_BEEF);
    tbl[2] = mk(1'b0, 32'h8000_0044, 32'h0, 3'b100, 32'hCAFE_F00D, 0, 1'b1, 4, 32'hDEAD_BEEF);
    tbl[3] = mk(1'b0, 32'h0000_0100, 32'h0, 3'b000, 32'h5555_5555, 0, 1'b0, 2, 32'hDEAD_BEEF);
    tbl[4] = mk(1'b0, 32'h8000_0200, 32'h0, 3'b010, 32'h0BAD_F00D, 2, 1'b0, 5, 32'h0BAD_F00D);
    tbl[5] = mk(1'b1, 32'h4000_0300, 32'hA5A5_5A5A, 3'b001, 32'h0, 1, 1'b1, 6, 32'h0BAD_F00D);

    hresetn = 1'b0; valid = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0;
    tempselx = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge hclk);
    check("reset outputs",
          psel === '0 && penable === 1'b0 && hr_readyout === 1'b1 && hresp === 1'b0 &&
          paddr === '0 && pwdata === '0 && pwrite === 1'b0 && hrdata === '0,
          $sformatf("sel=%b en=%b rdy=%b resp=%b a=%h wd=%h rd=%h", psel, penable,
                    hr_readyout, hresp, paddr, pwdata, hrdata),
          "all zero, rdy=1");
    hresetn = 1'b1;
    @(negedge hclk);
    check("idle after release", psel === '0 && hr_readyout === 1'b1 && hresp === 1'b0,
          $sformatf("sel=%b rdy=%b resp=%b", psel, hr_readyout, hresp), "sel=000 rdy=1 resp=0");

    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("dir%0d", i));

    for (int i = 0; i < 150; i++) begin
      txn_t t;
      t = mk(1'($urandom), $urandom, $urandom, rand_sel(), $urandom,
             $urandom_range(0, 5), ($urandom_range(0, 3) == 0), 0, '0);
      run_txn(t, $sformatf("rnd%0d", i));
    end

`ifdef APB_TIMEOUT_EN
    run_txn(mk(1'b0, 32'h8000_0400, 32'h0, 3'b010, 32'h1111_2222, 20, 1'b0, 7, m_hrdata),
            "timeout");
`else
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0400; tempselx = 3'b010; pready = 1'b0;
    @(posedge hclk);
    #1 valid = 1'b0;
    repeat (100) @(posedge hclk);
    @(negedge hclk);
    check("no timeout", psel === 3'b010 && penable === 1'b1 && hr_readyout === 1'b0 &&
          hresp === 1'b0, $sformatf("sel=%b en=%b rdy=%b resp=%b", psel, penable,
          hr_readyout, hresp), "sel=010 en=1 rdy=0 resp=0");
`endif

    // Start a read (or stay in a stuck ACCESS) and pull reset between clock edges.
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0500; tempselx = 3'b100; pready = 1'b0;
    @(posedge hclk);
    #1 valid = 1'b0;
    repeat (2) @(posedge hclk);
    #3 hresetn = 1'b0;
    #1;
    check("async reset", psel === '0 && penable === 1'b0 && hr_readyout === 1'b1 &&
          hresp === 1'b0 && paddr === '0 && hrdata === '0,
          $sformatf("sel=%b en=%b rdy=%b resp=%b a=%h rd=%h", psel, penable, hr_readyout,
                    hresp, paddr, hrdata), "all zero, rdy=1");
    @(negedge hclk);
    hresetn = 1'b1;
    repeat (2) @(negedge hclk);
    check("idle after async reset", psel === '0 && penable === 1'b0 && hr_readyout === 1'b1,
          $sformatf("sel=%b en=%b rdy=%b", psel, penable, hr_readyout), "sel=000 en=0 rdy=1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
